// File: rtl/pipe_cla_adder_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package pipe_cla_adder_pkg;

    localparam int GROUP = 4;

    // Pipeline depth: one stage per GPS look-ahead groups.
    function automatic int cla_latency(input int width, input int gps);
        return width / (GROUP * gps);
    endfunction

endpackage

// File: rtl/pipe_cla_adder_group4.sv
// 4-bit carry-lookahead group: generate/propagate, look-ahead carries, group sum.
module cla_group4
    import pipe_cla_adder_pkg::*;
(
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             c_i,
    output logic [GROUP-1:0] s_o,
    output logic             c_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i | b_i;

    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    // p is an OR, so the sum must use the XOR of the operands, not p.
    assign s_o = a_i ^ b_i ^ c[3:0];
    assign c_o = c[4];

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined CLA adder/subtractor: GPS groups resolved per stage, global stall.
module pipe_cla_adder
    import pipe_cla_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GPS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = GROUP * GPS;
    localparam int L  = cla_latency(WIDTH, GPS);

    if (GPS < 1 || WIDTH < SW || (WIDTH % SW) != 0) begin : g_param_err
        $error("pipe_cla_adder: WIDTH must be a non-zero multiple of 4*GPS");
    end

    logic stall;
    logic ovf_d;
    logic ovf_q;

    // Each stage carries only the still-unresolved operand bits above it and
    // the sum bits already resolved below it.
    for (genvar k = 0; k < L; k++) begin : g_st
        localparam int LO = k * SW;

        logic                 v_in;
        logic                 c_in;
        logic [WIDTH-1:LO]    a_in;
        logic [WIDTH-1:LO]    bx_in;
        logic [GPS:0]         cc;
        logic [SW-1:0]        gs;
        logic [LO+SW-1:0]     s_d;
        logic [LO+SW-1:0]     s_q;
        logic                 vld_q;
        logic                 c_q;

        if (k == 0) begin : g_src
            // Subtraction is A + ~B + 1; cin only matters for addition.
            assign v_in  = in_valid & in_ready;
            assign a_in  = a;
            assign bx_in = sub ? ~b : b;
            assign c_in  = sub | cin;
            assign s_d   = gs;
        end else begin : g_src
            assign v_in  = g_st[k-1].vld_q;
            assign a_in  = g_st[k-1].g_fwd.a_q;
            assign bx_in = g_st[k-1].g_fwd.bx_q;
            assign c_in  = g_st[k-1].c_q;
            assign s_d   = {gs, g_st[k-1].s_q};
        end

        assign cc[0] = c_in;

        for (genvar i = 0; i < GPS; i++) begin : g_grp
            cla_group4 u_grp (
                .a_i (a_in[LO+GROUP*i +: GROUP]),
                .b_i (bx_in[LO+GROUP*i +: GROUP]),
                .c_i (cc[i]),
                .s_o (gs[GROUP*i +: GROUP]),
                .c_o (cc[i+1])
            );
        end

        // Stage valid, carry and resolved sum bits; frozen while stalled.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                s_q   <= '0;
            end else if (!stall) begin
                vld_q <= v_in;
                c_q   <= cc[GPS];
                s_q   <= s_d;
            end
        end

        if (k < L - 1) begin : g_fwd
            logic [WIDTH-1:LO+SW] a_q;
            logic [WIDTH-1:LO+SW] bx_q;

            // Forward the operand bits later stages still need.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q  <= '0;
                    bx_q <= '0;
                end else if (!stall) begin
                    a_q  <= a_in[WIDTH-1:LO+SW];
                    bx_q <= bx_in[WIDTH-1:LO+SW];
                end
            end
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign ovf_d = g_st[L-1].a_in[WIDTH-1] ^ g_st[L-1].bx_in[WIDTH-1]
                 ^ g_st[L-1].s_d[WIDTH-1] ^ g_st[L-1].cc[GPS];

    // Signed-overflow flag registered alongside the final stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= ovf_d;
        end
    end

    // Reset overrides backpressure so in_ready stays high during reset.
    assign stall     = g_st[L-1].vld_q & ~out_ready & ~rst;
    assign in_ready  = ~stall;
    assign out_valid = g_st[L-1].vld_q;
    assign sum       = g_st[L-1].s_q;
    assign cout      = g_st[L-1].c_q;
    assign ovf       = ovf_q;

endmodule
